ssd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for an NDIG-digit common-anode seven-segment display.
- Drives a single shared BCD-to-seven-segment decoder through BCDOut.
- Strobes one digit at a time, with a dead-time gap between slots to suppress ghosting.
- Holds a double-buffered display value with a load handshake, and supports leading-zero blanking.

---
 rtl/ssd_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - time-multiplexed seven-segment scan controller with double-buffered load
module ssd_scan_ctrl #(
  parameter int NDIG     = 4,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Enable,
  input  logic              BlankLZ,
  input  logic              LoadReq,
  input  logic [4*NDIG-1:0] ValueIn,
  input  logic [NDIG-1:0]   DPIn,
  output logic              Busy,
  output logic              LoadAck,
  output logic [3:0]        BCDOut,
  output logic              DPOut,
  output logic [NDIG-1:0]   DigitSel
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Slot counter runs over the whole slot; ON covers the first PRESCALE-DEADTIME counts.
  localparam logic [CW-1:0] LAST_CNT = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] LAST_ON  = CW'(PRESCALE - DEADTIME - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [4*NDIG-1:0] act_val;
  logic [NDIG-1:0]   act_dp;
  logic [4*NDIG-1:0] pend_val;
  logic [NDIG-1:0]   pend_dp;

  logic              slot_start;
  logic [IW-1:0]     next_idx;
  logic              xfer;
  logic [4*NDIG-1:0] src_val;
  logic [NDIG-1:0]   src_dp;
  logic [3:0]        src_nib;
  logic [NDIG-1:0]   lz_mask;
  logic              nz_seen;
  logic              slot_blank;

  // Decide whether the next edge begins a new ON slot, and what that slot will display.
  // When the pending value is being promoted on this edge, the slot is built from it
  // directly so the first cycle of digit 0 already shows the new frame.
  always_comb begin
    slot_start = 1'b0;
    next_idx   = '0;
    xfer       = 1'b0;
    src_val    = act_val;
    src_dp     = act_dp;
    src_nib    = 4'd0;
    lz_mask    = '0;
    nz_seen    = 1'b0;
    slot_blank = 1'b0;

    if (Enable) begin
      if (state == IDLE) begin
        slot_start = 1'b1;
      end else if (cnt == LAST_CNT) begin
        slot_start = 1'b1;
        next_idx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end

    // Promotion only at a frame boundary (or any time while dark), so frames never tear.
    xfer = Busy && ((state == IDLE) || (slot_start && (next_idx == '0)));

    if (xfer) begin
      src_val = pend_val;
      src_dp  = pend_dp;
    end

    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == next_idx) begin
        src_nib = src_val[i*4 +: 4];
      end
    end

    // A digit is a leading zero when it and everything above it are zero; digit 0 always shows.
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz_seen    = nz_seen | (src_val[i*4 +: 4] != 4'd0);
      lz_mask[i] = ~nz_seen;
    end
    lz_mask[0] = 1'b0;

    slot_blank = BlankLZ && lz_mask[next_idx];
  end

  // Scan FSM, load handshake and all registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      act_val  <= '0;
      act_dp   <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      Busy     <= 1'b0;
      LoadAck  <= 1'b0;
      BCDOut   <= 4'd0;
      DPOut    <= 1'b0;
      DigitSel <= '1;
    end else begin
      LoadAck <= 1'b0;

      // Busy is still high on a promotion edge, so a coincident LoadReq is dropped.
      if (xfer) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
        Busy    <= 1'b0;
        LoadAck <= 1'b1;
      end else if (LoadReq && !Busy) begin
        pend_val <= ValueIn;
        pend_dp  <= DPIn;
        Busy     <= 1'b1;
      end

      if (!Enable) begin
        state    <= IDLE;
        idx      <= '0;
        cnt      <= '0;
        DigitSel <= '1;
      end else if (slot_start) begin
        state    <= ON;
        idx      <= next_idx;
        cnt      <= '0;
        BCDOut   <= src_nib;
        DPOut    <= src_dp[next_idx] & ~slot_blank;
        DigitSel <= slot_blank ? '1 : ~(NDIG'(1) << next_idx);
      end else begin
        cnt <= cnt + 1'b1;
        if ((state == ON) && (cnt == LAST_ON)) begin
          state    <= GAP;
          DigitSel <= '1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - randomized self-checking bench for ssd_scan_ctrl
module tb_ssd_scan_ctrl;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 8;
  localparam int DEADTIME = 2;
  localparam int ONLEN    = PRESCALE - DEADTIME;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        en   = 1'b0;
  logic        blz  = 1'b0;
  logic        lreq = 1'b0;
  logic [15:0] vin  = 16'h0;
  logic [3:0]  dpin = 4'h0;
  logic        busy;
  logic        ack;
  logic [3:0]  bcd;
  logic        dpout;
  logic [3:0]  sel;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRESCALE), .DEADTIME(DEADTIME)) dut (
    .Clk(clk), .Rst(rst), .Enable(en), .BlankLZ(blz), .LoadReq(lreq),
    .ValueIn(vin), .DPIn(dpin), .Busy(busy), .LoadAck(ack),
    .BCDOut(bcd), .DPOut(dpout), .DigitSel(sel)
  );

  // Reference model: time since scan start, slot = t/PRESCALE, phase = t%PRESCALE.
  bit          m_run;
  int          m_t;
  int          m_dig;
  logic [15:0] m_act, m_pend;
  logic [3:0]  m_actdp, m_penddp;
  bit          m_busy, m_ack, m_blank, m_dp;
  logic [3:0]  m_bcd, m_sel;
  bit          was_run, start, xfer;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_dig = 0;
      m_act = 0; m_pend = 0; m_actdp = 0; m_penddp = 0;
      m_busy = 0; m_ack = 0; m_blank = 0; m_dp = 0;
      m_bcd = 0; m_sel = 4'hF;
    end else begin
      was_run = m_run;
      start   = 0;
      m_ack   = 0;
      if (!en) m_run = 0;
      else if (!m_run) begin m_run = 1; m_t = 0; start = 1; end
      else begin m_t = m_t + 1; start = ((m_t % PRESCALE) == 0); end
      m_dig = (m_t / PRESCALE) % NDIG;
      xfer = m_busy && (!was_run || (start && m_dig == 0));
      if (xfer) begin
        m_act = m_pend; m_actdp = m_penddp; m_busy = 0; m_ack = 1;
      end else if (lreq && !m_busy) begin
        m_pend = vin; m_penddp = dpin; m_busy = 1;
      end
      if (start) begin
        m_blank = blz && (m_dig > 0) && ((m_act >> (4 * m_dig)) == 16'h0);
        m_bcd   = 4'((m_act >> (4 * m_dig)) & 16'hF);
        m_dp    = m_actdp[m_dig] && !m_blank;
      end
      if (m_run && ((m_t % PRESCALE) < ONLEN) && !m_blank) m_sel = ~(4'b1 << m_dig);
      else m_sel = 4'hF;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("DigitSel", 32'(sel), 32'(m_sel));
      check("BCDOut", 32'(bcd), 32'(m_bcd));
      check("DPOut", 32'(dpout), 32'(m_dp));
      check("Busy", 32'(busy), 32'(m_busy));
      check("LoadAck", 32'(ack), 32'(m_ack));
    end
  end

  task automatic goto(input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    lreq = 1'b1; vin = v; dpin = d;
  endtask

  initial begin
    int lead;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_bcd", 32'(bcd), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dp", 32'(dpout), 32'h0);
    rst = 1'b0; en = 1'b1; k = -1;

    // Plain scan pattern
    goto(0);  check("s1_k0", 32'(sel), 32'hE);
    goto(5);  check("s1_k5", 32'(sel), 32'hE);
    goto(6);  check("s1_k6", 32'(sel), 32'hF);
    goto(7);  check("s1_k7", 32'(sel), 32'hF);
    goto(8);  check("s1_k8", 32'(sel), 32'hD);
    goto(14); check("s1_k14", 32'(sel), 32'hF);
    goto(16); check("s1_k16", 32'(sel), 32'hB);
    goto(24); check("s1_k24", 32'(sel), 32'h7); check("s1_bcd", 32'(bcd), 32'h0);
    goto(30); check("s1_k30", 32'(sel), 32'hF);
    goto(32); check("s1_k32", 32'(sel), 32'hE);

    // Load during digit 1, promoted at next digit-0 slot
    goto(40); load(16'h1234, 4'b0100);
    goto(41); lreq = 1'b0; check("s2_busy", 32'(busy), 32'h1);
    goto(48); check("s2_old", 32'(bcd), 32'h0);
    goto(63); check("s2_noack", 32'(ack), 32'h0); check("s2_busy63", 32'(busy), 32'h1);
    goto(64); check("s2_ack", 32'(ack), 32'h1); check("s2_nbusy", 32'(busy), 32'h0);
              check("s2_d0", 32'(bcd), 32'h4); check("s2_sel0", 32'(sel), 32'hE);
    goto(65); check("s2_ack1", 32'(ack), 32'h0);
    goto(72); check("s2_d1", 32'(bcd), 32'h3); check("s2_dp1", 32'(dpout), 32'h0);
    goto(80); check("s2_d2", 32'(bcd), 32'h2); check("s2_dp2", 32'(dpout), 32'h1);
    goto(86); check("s2_gap", 32'(sel), 32'hF); check("s2_gapdp", 32'(dpout), 32'h1);
    goto(88); check("s2_d3", 32'(bcd), 32'h1); check("s2_dp3", 32'(dpout), 32'h0);

    // Second request while busy is ignored
    goto(90); load(16'h5678, 4'b0000);
    goto(91); vin = 16'h9999; check("s3_busy", 32'(busy), 32'h1);
    goto(92); lreq = 1'b0;
    goto(96); check("s3_ack", 32'(ack), 32'h1); check("s3_d0", 32'(bcd), 32'h8);
    goto(104); check("s3_d1", 32'(bcd), 32'h7);
    goto(105); load(16'h0050, 4'b0000); blz = 1'b1;
    goto(106); lreq = 1'b0; check("s3_acc", 32'(busy), 32'h1);

    // Leading-zero blanking
    goto(128); check("s4_d0", 32'(bcd), 32'h0); check("s4_sel0", 32'(sel), 32'hE);
    goto(136); check("s4_d1", 32'(bcd), 32'h5); check("s4_sel1", 32'(sel), 32'hD);
    goto(144); check("s4_sel2", 32'(sel), 32'hF); check("s4_dp2", 32'(dpout), 32'h0);
    goto(149); check("s4_sel2b", 32'(sel), 32'hF);
    goto(152); check("s4_sel3", 32'(sel), 32'hF);
    goto(161); load(16'h0000, 4'b0000);
    goto(162); lreq = 1'b0;
    goto(192); check("s4_z0", 32'(sel), 32'hE);
    goto(200); check("s4_z1", 32'(sel), 32'hF);
    goto(208); check("s4_z2", 32'(sel), 32'hF);
    goto(217); load(16'h0A00, 4'b0000);
    goto(218); lreq = 1'b0;
    goto(232); check("s4_a1", 32'(sel), 32'hD); check("s4_a1b", 32'(bcd), 32'h0);
    goto(240); check("s4_a2", 32'(sel), 32'hB); check("s4_a2b", 32'(bcd), 32'hA);

    // Disable mid-slot, load while dark, re-enable
    goto(242); en = 1'b0;
    goto(243); check("s5_dark", 32'(sel), 32'hF);
    goto(245); load(16'h4321, 4'b0000);
    goto(246); lreq = 1'b0; check("s5_busy", 32'(busy), 32'h1); check("s5_noack", 32'(ack), 32'h0);
    goto(247); check("s5_ack", 32'(ack), 32'h1); check("s5_nbusy", 32'(busy), 32'h0);
    goto(250); en = 1'b1;
    goto(251); check("s5_on", 32'(sel), 32'hE); check("s5_bcd", 32'(bcd), 32'h1);
    goto(256); check("s5_on6", 32'(sel), 32'hE);
    goto(257); check("s5_gap", 32'(sel), 32'hF);

    // Asynchronous reset with a load pending
    goto(260); load(16'h7777, 4'b1111);
    goto(261); lreq = 1'b0; check("s6_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("s6_sel", 32'(sel), 32'hF);
    check("s6_bcd", 32'(bcd), 32'h0);
    check("s6_dp", 32'(dpout), 32'h0);
    check("s6_busy0", 32'(busy), 32'h0);
    check("s6_ack", 32'(ack), 32'h0);
    @(negedge clk); rst = 1'b0; k = -1;
    goto(0); check("s6_sel0", 32'(sel), 32'hE); check("s6_bcd0", 32'(bcd), 32'h0);
             check("s6_nbusy", 32'(busy), 32'h0);
    goto(6); check("s6_gap", 32'(sel), 32'hF);

    // Randomized traffic, checked cycle by cycle against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      lreq = ($urandom_range(0, 11) == 0);
      lead = $urandom_range(0, 4);
      vin  = 16'($urandom) & (16'hFFFF >> (4 * lead));
      if ($urandom_range(0, 3) == 0) vin[7:4] = 4'h0;
      dpin = 4'($urandom);
      if (en) begin
        if ($urandom_range(0, 79) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      if ($urandom_range(0, 799) == 0) begin
        #3 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
